// File: rtl/icache_sa_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Holds the default geometry, the controller state encoding and a small
// helper that sizes index fields so they never collapse to zero width.
package icache_sa_pkg;

    localparam int unsigned DefXlen      = 32;
    localparam int unsigned DefWays      = 2;
    localparam int unsigned DefSets      = 16;
    localparam int unsigned DefBlockSize = 4;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StRefill = 1'b1
    } cache_state_e;

    // Width of an index selecting one of n items, never less than one bit.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_sa_plru_tree.sv
// plru_tree: tree pseudo-LRU state for one cache set.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_update      mark i_way as most recently used at the next edge
//   i_way         way being accessed
//   o_victim      way to replace next (pseudo least recently used)
// Tree bits point towards the less recently used half.
module plru_tree
    import icache_sa_pkg::*;
#(
    parameter int unsigned WAYS = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_update,
    input  logic [idx_bits(WAYS)-1:0]   i_way,
    output logic [idx_bits(WAYS)-1:0]   o_victim
);

    if (WAYS == 1) begin : g_one
        assign o_victim = '0;
    end else if (WAYS == 2) begin : g_two
        logic bit_q, bit_d;

        always_comb begin
            bit_d = bit_q;
            if (i_update) begin
                bit_d = ~i_way[0];
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                bit_q <= 1'b0;
            end else begin
                bit_q <= bit_d;
            end
        end

        assign o_victim = bit_q;
    end else begin : g_four
        // [0] root, [1] picks within ways 0/1, [2] picks within ways 2/3.
        logic [2:0] bits_q, bits_d;

        always_comb begin
            bits_d = bits_q;
            if (i_update) begin
                bits_d[0] = ~i_way[1];
                if (!i_way[1]) begin
                    bits_d[1] = ~i_way[0];
                end else begin
                    bits_d[2] = ~i_way[0];
                end
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                bits_q <= '0;
            end else begin
                bits_q <= bits_d;
            end
        end

        assign o_victim = bits_q[0] ? {1'b1, bits_q[2]} : {1'b0, bits_q[1]};
    end

endmodule

// File: rtl/icache_sa.sv
// icache_sa: set-associative, read-only instruction cache with word-by-word refill.
// Ports:
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_req, i_Addr              fetch request and byte address (held while stalled)
//   i_flush                    invalidate every line (FENCE.I)
//   o_Data, o_Stall            fetched word, fetch-not-served indication
//   o_hit, o_miss              one-cycle event pulses
//   o_DataReq, o_MemAddr       refill word request and word-aligned address
//   i_DataBlock, i_MemReady    refill word and its one-cycle acknowledge
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int unsigned XLEN       = DefXlen,
    parameter int unsigned WAYS       = DefWays,
    parameter int unsigned SETS       = DefSets,
    parameter int unsigned BLOCK_SIZE = DefBlockSize
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_Addr,
    input  logic            i_flush,
    output logic [XLEN-1:0] o_Data,
    output logic            o_Stall,
    output logic            o_hit,
    output logic            o_miss,
    output logic            o_DataReq,
    output logic [XLEN-1:0] o_MemAddr,
    input  logic [XLEN-1:0] i_DataBlock,
    input  logic            i_MemReady
);

    localparam int unsigned WordBits  = $clog2(BLOCK_SIZE);
    localparam int unsigned IndexBits = $clog2(SETS);
    localparam int unsigned WordW     = idx_bits(BLOCK_SIZE);
    localparam int unsigned WayW      = idx_bits(WAYS);
    localparam int unsigned TagW      = XLEN - 2 - WordBits - IndexBits;
    localparam int unsigned LineBytes = 4 * BLOCK_SIZE;

    // Storage; data and tags carry no reset, validity is tracked separately.
    logic [XLEN-1:0] data_q  [WAYS][SETS][BLOCK_SIZE];
    logic [TagW-1:0] tag_q   [WAYS][SETS];
    logic [SETS-1:0] valid_q [WAYS];
    logic [SETS-1:0] valid_d [WAYS];

    cache_state_e    state_q, state_d;
    logic [WordW-1:0] k_q, k_d;
    logic [XLEN-1:0] miss_base_q, miss_base_d;
    logic [WayW-1:0] victim_q, victim_d;
    logic            flush_pend_q, flush_pend_d;

    logic [WordW-1:0]     req_word;
    logic [IndexBits-1:0] req_idx;
    logic [TagW-1:0]      req_tag;
    logic [IndexBits-1:0] miss_idx;
    logic [TagW-1:0]      miss_tag;
    logic                 req_act;

    logic [WAYS-1:0] hit_way;
    logic [WayW-1:0] hit_idx;
    logic            lookup_hit;
    logic [WayW-1:0] inv_way;
    logic            any_inv;
    logic [WayW-1:0] victim_sel;
    logic [WayW-1:0] plru_victim [SETS];

    logic                 plru_upd;
    logic [IndexBits-1:0] plru_set;
    logic [WayW-1:0]      plru_way;
    logic                 refill_we;
    logic                 last_word;

    assign req_word = WordW'((i_Addr >> 2) & XLEN'(BLOCK_SIZE - 1));
    assign req_idx  = IndexBits'(i_Addr >> (2 + WordBits));
    assign req_tag  = TagW'(i_Addr >> (2 + WordBits + IndexBits));
    assign miss_idx = IndexBits'(miss_base_q >> (2 + WordBits));
    assign miss_tag = TagW'(miss_base_q >> (2 + WordBits + IndexBits));

    // Requests seen while reset is held must not raise event pulses.
    assign req_act   = i_req & ~i_rst;
    assign last_word = (k_q == WordW'(BLOCK_SIZE - 1));

    always_comb begin
        hit_way = '0;
        hit_idx = '0;
        inv_way = '0;
        any_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hit_way[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
        end
        // Descending scan so the lowest matching / invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_way[w]) begin
                hit_idx = WayW'(w);
            end
            if (!valid_q[w][req_idx]) begin
                inv_way = WayW'(w);
                any_inv = 1'b1;
            end
        end
        lookup_hit = |hit_way;
        victim_sel = any_inv ? inv_way : plru_victim[req_idx];
    end

    assign o_Data    = data_q[hit_idx][req_idx][req_word];
    assign o_MemAddr = miss_base_q | (XLEN'(k_q) << 2);

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        miss_base_d  = miss_base_q;
        victim_d     = victim_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        o_Stall      = 1'b0;
        o_hit        = 1'b0;
        o_miss       = 1'b0;
        o_DataReq    = 1'b0;
        plru_upd     = 1'b0;
        plru_set     = req_idx;
        plru_way     = hit_idx;
        refill_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_act) begin
                    if (lookup_hit) begin
                        o_hit    = 1'b1;
                        plru_upd = 1'b1;
                    end else begin
                        o_Stall     = 1'b1;
                        o_miss      = 1'b1;
                        miss_base_d = i_Addr & ~XLEN'(LineBytes - 1);
                        victim_d    = victim_sel;
                        k_d         = '0;
                        state_d     = StRefill;
                    end
                end
                // Lookup above already used the pre-flush valid bits.
                if (i_flush) begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_d[w] = '0;
                    end
                end
            end
            StRefill: begin
                o_Stall   = 1'b1;
                o_DataReq = 1'b1;
                if (i_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (i_MemReady) begin
                    refill_we = 1'b1;
                    k_d       = k_q + WordW'(1);
                    if (last_word) begin
                        state_d  = StIdle;
                        k_d      = '0;
                        plru_upd = 1'b1;
                        plru_set = miss_idx;
                        plru_way = victim_q;
                        if (flush_pend_q || i_flush) begin
                            // Deferred FENCE.I also drops the line just filled.
                            for (int w = 0; w < WAYS; w++) begin
                                valid_d[w] = '0;
                            end
                            flush_pend_d = 1'b0;
                        end else begin
                            valid_d[victim_q][miss_idx] = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            k_q          <= '0;
            miss_base_q  <= '0;
            victim_q     <= '0;
            flush_pend_q <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            miss_base_q  <= miss_base_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (refill_we) begin
            data_q[victim_q][miss_idx][k_q] <= i_DataBlock;
            if (last_word) begin
                tag_q[victim_q][miss_idx] <= miss_tag;
            end
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_plru
        plru_tree #(
            .WAYS(WAYS)
        ) u_plru (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_update(plru_upd && (plru_set == IndexBits'(s))),
            .i_way   (plru_way),
            .o_victim(plru_victim[s])
        );
    end

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa (WAYS=2, SETS=16, BLOCK_SIZE=4).
// The memory model returns data equal to the requested address after a
// configurable number of wait cycles.
module tb_icache_sa;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr_r = '0;
    logic        flush = 1'b0;
    logic [31:0] data_o;
    logic        stall, hit, miss, dreq;
    logic [31:0] mem_addr;
    logic [31:0] data_blk;
    logic        mem_ready;
    logic        force_ready = 1'b0;
    int          mem_lat = 0;
    int          wait_cnt = 0;
    logic [31:0] ack_log [$];

    int n_total = 0;
    int n_bad   = 0;

    icache_sa #(
        .XLEN      (32),
        .WAYS      (2),
        .SETS      (16),
        .BLOCK_SIZE(4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_Addr     (addr_r),
        .i_flush    (flush),
        .o_Data     (data_o),
        .o_Stall    (stall),
        .o_hit      (hit),
        .o_miss     (miss),
        .o_DataReq  (dreq),
        .o_MemAddr  (mem_addr),
        .i_DataBlock(data_blk),
        .i_MemReady (mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_ready = force_ready | (dreq && (wait_cnt == mem_lat));
    assign data_blk  = mem_addr;

    always @(posedge clk) begin
        if (dreq && mem_ready) ack_log.push_back(mem_addr);
        if (rst || !dreq || mem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Holds a request until served; pulses i_flush in stall cycle flush_at.
    task automatic fetch(input logic [31:0] a, input int flush_at, output int stalls,
                         output int misses, output int hits, output logic [31:0] data);
        int cyc = 0;
        bit done = 1'b0;
        stalls = 0;
        misses = 0;
        hits   = 0;
        data   = '0;
        @(negedge clk);
        req    = 1'b1;
        addr_r = a;
        while (!done && cyc < 100) begin
            flush = (cyc == flush_at);
            #1;
            if (miss) misses++;
            if (hit) hits++;
            if (!stall) begin
                done = 1'b1;
                data = data_o;
            end else begin
                stalls++;
            end
            cyc++;
            @(negedge clk);
        end
        req   = 1'b0;
        flush = 1'b0;
        check_eq("fetch_done", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int st, ms, ht, base;
        logic [31:0] d;

        // Reset state.
        #12;
        check_eq("rst_dreq", 32'(dreq), 32'd0);
        check_eq("rst_hit", 32'(hit), 32'd0);
        check_eq("rst_miss", 32'(miss), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, single-cycle memory.
        base = ack_log.size();
        fetch(32'h100, -1, st, ms, ht, d);
        check_eq("cold_stall", 32'(st), 32'd5);
        check_eq("cold_miss", 32'(ms), 32'd1);
        check_eq("cold_data", d, 32'h100);
        check_eq("cold_nwords", 32'(ack_log.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("cold_addr", ack_log[base + i], 32'h100 + 32'(4 * i));
        end
        fetch(32'h108, -1, st, ms, ht, d);
        check_eq("hit108_stall", 32'(st), 32'd0);
        check_eq("hit108_hit", 32'(ht), 32'd1);
        check_eq("hit108_data", d, 32'h108);

        // PLRU replacement within set 0.
        fetch(32'h1100, -1, st, ms, ht, d);
        check_eq("fill1100_miss", 32'(ms), 32'd1);
        fetch(32'h100, -1, st, ms, ht, d);
        check_eq("touch100_stall", 32'(st), 32'd0);
        fetch(32'h2100, -1, st, ms, ht, d);
        check_eq("fill2100_miss", 32'(ms), 32'd1);
        fetch(32'h10C, -1, st, ms, ht, d);
        check_eq("keep100_stall", 32'(st), 32'd0);
        check_eq("keep100_data", d, 32'h10C);
        fetch(32'h2104, -1, st, ms, ht, d);
        check_eq("keep2100_stall", 32'(st), 32'd0);
        check_eq("keep2100_data", d, 32'h2104);
        fetch(32'h1104, -1, st, ms, ht, d);
        check_eq("evict1100_miss", 32'(ms), 32'd1);
        check_eq("evict1100_data", d, 32'h1104);

        // Two wait cycles per word: 1 + 4*3 stall cycles.
        do_reset();
        mem_lat = 2;
        fetch(32'h500, -1, st, ms, ht, d);
        check_eq("lat2_stall", 32'(st), 32'd13);
        check_eq("lat2_data", d, 32'h500);
        mem_lat = 0;

        // Flush coincident with a hit: lookup still sees the line.
        fetch(32'h504, 0, st, ms, ht, d);
        check_eq("flushhit_stall", 32'(st), 32'd0);
        check_eq("flushhit_data", d, 32'h504);
        fetch(32'h500, -1, st, ms, ht, d);
        check_eq("postflush_miss", 32'(ms), 32'd1);
        check_eq("postflush_stall", 32'(st), 32'd5);

        // Idle flush pulse with no request.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fetch(32'h500, -1, st, ms, ht, d);
        check_eq("idleflush_miss", 32'(ms), 32'd1);

        // Flush during second refill word: refill completes, retry misses again.
        do_reset();
        base = ack_log.size();
        fetch(32'h200, 2, st, ms, ht, d);
        check_eq("rflush_nwords", 32'(ack_log.size() - base), 32'd8);
        check_eq("rflush_miss", 32'(ms), 32'd2);
        check_eq("rflush_stall", 32'(st), 32'd10);
        check_eq("rflush_data", d, 32'h200);

        // Stray acknowledges while idle are ignored.
        @(negedge clk);
        force_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        force_ready = 1'b0;
        fetch(32'h204, -1, st, ms, ht, d);
        check_eq("stray_stall", 32'(st), 32'd0);
        check_eq("stray_data", d, 32'h204);

        // Reset in the middle of a refill.
        @(negedge clk);
        req    = 1'b1;
        addr_r = 32'h300;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("midrefill_dreq", 32'(dreq), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_dreq", 32'(dreq), 32'd0);
        check_eq("abort_miss", 32'(miss), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        fetch(32'h300, -1, st, ms, ht, d);
        check_eq("after_abort_miss", 32'(ms), 32'd1);
        check_eq("after_abort_stall", 32'(st), 32'd5);

        // No request, uncached address.
        @(negedge clk);
        req    = 1'b0;
        addr_r = 32'h400;
        #1;
        check_eq("noreq_stall", 32'(stall), 32'd0);
        check_eq("noreq_dreq", 32'(dreq), 32'd0);
        check_eq("noreq_miss", 32'(miss), 32'd0);
        check_eq("noreq_hit", 32'(hit), 32'd0);
        @(negedge clk);
        #1;
        check_eq("noreq_dreq2", 32'(dreq), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
